// File: rtl/uart_axi_slave.sv
// AXI4-lite responder presenting a UART-lite register map over an RX byte FIFO
// (filled from a byte stream) and a TX byte FIFO (drained onto a byte stream).
module uart_axi_slave #(
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [3:0]  uart_axi_araddr,
    input  logic        uart_axi_arvalid,
    output logic        uart_axi_arready,
    output logic [31:0] uart_axi_rdata,
    output logic [1:0]  uart_axi_rresp,
    output logic        uart_axi_rvalid,
    input  logic        uart_axi_rready,
    input  logic [3:0]  uart_axi_awaddr,
    input  logic        uart_axi_awvalid,
    output logic        uart_axi_awready,
    input  logic [31:0] uart_axi_wdata,
    input  logic [3:0]  uart_axi_wstrb,
    input  logic        uart_axi_wvalid,
    output logic        uart_axi_wready,
    output logic [1:0]  uart_axi_bresp,
    output logic        uart_axi_bvalid,
    input  logic        uart_axi_bready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        interrupt
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    logic [PW-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
    logic [PW-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
    logic [7:0]    rx_mem [FIFO_DEPTH];
    logic [7:0]    tx_mem [FIFO_DEPTH];

    logic        arready_q, arready_d, rvalid_q, rvalid_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  rresp_q, rresp_d;
    logic        awready_q, awready_d, wready_q, wready_d;
    logic        aw_have_q, aw_have_d, w_have_q, w_have_d;
    logic [1:0]  awsel_q, awsel_d;
    logic [7:0]  wbyte_q, wbyte_d;
    logic        wstb_q, wstb_d;
    logic        bvalid_q, bvalid_d;
    logic [1:0]  bresp_q, bresp_d;
    logic        ie_q, ie_d, ovr_q, ovr_d;
    logic        txe_lat_q, txe_lat_d, txe_prev_q, txe_prev_d;

    logic        rx_empty, rx_full, tx_empty, tx_full;
    logic        ar_hs, r_hs, aw_hs, w_hs, b_hs, wr_go;
    logic        rx_pop, rx_push, tx_pop, tx_push;
    logic        ctrl_wr, flush_rx, flush_tx, stat_rd;
    logic [1:0]  arsel;
    logic [31:0] stat;
    logic        unused_ok;

    assign rx_empty = (rx_wp_q == rx_rp_q);
    assign rx_full  = (rx_wp_q[AW] != rx_rp_q[AW]) && (rx_wp_q[AW-1:0] == rx_rp_q[AW-1:0]);
    assign tx_empty = (tx_wp_q == tx_rp_q);
    assign tx_full  = (tx_wp_q[AW] != tx_rp_q[AW]) && (tx_wp_q[AW-1:0] == tx_rp_q[AW-1:0]);

    assign ar_hs = uart_axi_arvalid && arready_q;
    assign r_hs  = rvalid_q && uart_axi_rready;
    assign aw_hs = uart_axi_awvalid && awready_q;
    assign w_hs  = uart_axi_wvalid && wready_q;
    assign b_hs  = bvalid_q && uart_axi_bready;
    // Register side effects happen once both address and data have been captured.
    assign wr_go = aw_have_q && w_have_q;

    assign arsel    = uart_axi_araddr[3:2];
    assign stat     = {26'b0, ovr_q, ie_q, tx_full, tx_empty, rx_full, !rx_empty};
    assign stat_rd  = ar_hs && (arsel == 2'd2);
    assign rx_pop   = ar_hs && (arsel == 2'd0) && !rx_empty;
    assign rx_push  = rx_valid && (!rx_full || rx_pop);
    assign tx_pop   = !tx_empty && tx_ready;
    assign tx_push  = wr_go && (awsel_q == 2'd1) && wstb_q && (!tx_full || tx_pop);
    assign ctrl_wr  = wr_go && (awsel_q == 2'd3) && wstb_q;
    assign flush_tx = ctrl_wr && wbyte_q[0];
    assign flush_rx = ctrl_wr && wbyte_q[1];

    assign unused_ok = ^{uart_axi_araddr[1:0], uart_axi_awaddr[1:0],
                         uart_axi_wdata[31:8], uart_axi_wstrb[3:1]};

    always_comb begin
        arready_d  = arready_q;
        rvalid_d   = rvalid_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        awready_d  = awready_q;
        wready_d   = wready_q;
        aw_have_d  = aw_have_q;
        w_have_d   = w_have_q;
        awsel_d    = awsel_q;
        wbyte_d    = wbyte_q;
        wstb_d     = wstb_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        ie_d       = ie_q;
        ovr_d      = ovr_q;
        txe_prev_d = tx_empty;
        txe_lat_d  = txe_lat_q;
        rx_wp_d    = rx_wp_q + PW'(rx_push);
        rx_rp_d    = rx_rp_q + PW'(rx_pop);
        tx_wp_d    = tx_wp_q + PW'(tx_push);
        tx_rp_d    = tx_rp_q + PW'(tx_pop);

        if (ar_hs)
            arready_d = 1'b0;
        else if (r_hs || !rvalid_q)
            arready_d = 1'b1;

        if (ar_hs) begin
            rvalid_d = 1'b1;
            case (arsel)
                2'd0: begin
                    rdata_d = rx_empty ? 32'd0 : {24'b0, rx_mem[rx_rp_q[AW-1:0]]};
                    rresp_d = OKAY;
                end
                2'd2: begin
                    rdata_d = stat;
                    rresp_d = OKAY;
                end
                default: begin
                    rdata_d = 32'd0;
                    rresp_d = SLVERR;
                end
            endcase
        end else if (r_hs) begin
            rvalid_d = 1'b0;
        end

        if (aw_hs)
            awready_d = 1'b0;
        else if (b_hs || (!aw_have_q && !bvalid_q))
            awready_d = 1'b1;
        if (w_hs)
            wready_d = 1'b0;
        else if (b_hs || (!w_have_q && !bvalid_q))
            wready_d = 1'b1;

        if (aw_hs) begin
            aw_have_d = 1'b1;
            awsel_d   = uart_axi_awaddr[3:2];
        end else if (wr_go) begin
            aw_have_d = 1'b0;
        end
        if (w_hs) begin
            w_have_d = 1'b1;
            wbyte_d  = uart_axi_wdata[7:0];
            wstb_d   = uart_axi_wstrb[0];
        end else if (wr_go) begin
            w_have_d = 1'b0;
        end

        if (wr_go) begin
            bvalid_d = 1'b1;
            bresp_d  = awsel_q[0] ? OKAY : SLVERR;
        end else if (b_hs) begin
            bvalid_d = 1'b0;
        end

        if (ctrl_wr)
            ie_d = wbyte_q[4];
        if (rx_valid && !rx_push)
            ovr_d = 1'b1;
        else if (stat_rd)
            ovr_d = 1'b0;
        if (tx_empty && !txe_prev_q)
            txe_lat_d = 1'b1;
        else if (stat_rd)
            txe_lat_d = 1'b0;

        if (flush_rx) begin
            rx_wp_d = '0;
            rx_rp_d = '0;
        end
        if (flush_tx) begin
            tx_wp_d = '0;
            tx_rp_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= OKAY;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            aw_have_q  <= 1'b0;
            w_have_q   <= 1'b0;
            awsel_q    <= '0;
            wbyte_q    <= '0;
            wstb_q     <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= OKAY;
            ie_q       <= 1'b0;
            ovr_q      <= 1'b0;
            txe_prev_q <= 1'b1;
            txe_lat_q  <= 1'b0;
            rx_wp_q    <= '0;
            rx_rp_q    <= '0;
            tx_wp_q    <= '0;
            tx_rp_q    <= '0;
        end else begin
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            aw_have_q  <= aw_have_d;
            w_have_q   <= w_have_d;
            awsel_q    <= awsel_d;
            wbyte_q    <= wbyte_d;
            wstb_q     <= wstb_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            ie_q       <= ie_d;
            ovr_q      <= ovr_d;
            txe_prev_q <= txe_prev_d;
            txe_lat_q  <= txe_lat_d;
            rx_wp_q    <= rx_wp_d;
            rx_rp_q    <= rx_rp_d;
            tx_wp_q    <= tx_wp_d;
            tx_rp_q    <= tx_rp_d;
        end
    end

    // Storage needs no reset: pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (rx_push)
            rx_mem[rx_wp_q[AW-1:0]] <= rx_data;
        if (tx_push)
            tx_mem[tx_wp_q[AW-1:0]] <= wbyte_q;
    end

    assign uart_axi_arready = arready_q;
    assign uart_axi_rvalid  = rvalid_q;
    assign uart_axi_rdata   = rdata_q;
    assign uart_axi_rresp   = rresp_q;
    assign uart_axi_awready = awready_q;
    assign uart_axi_wready  = wready_q;
    assign uart_axi_bvalid  = bvalid_q;
    assign uart_axi_bresp   = bresp_q;
    assign tx_valid         = !tx_empty;
    assign tx_data          = tx_mem[tx_rp_q[AW-1:0]];
    assign interrupt        = ie_q & (!rx_empty | txe_lat_q);

endmodule

// File: tb/tb_uart_axi_slave.sv
// Randomized bench for uart_axi_slave against a queue-based model of the
// register map, FIFOs, overrun flag and interrupt.
module tb_uart_axi_slave;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [3:0]  araddr = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b0;
    logic [3:0]  awaddr = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic        interrupt;

    always #5 clk = ~clk;

    uart_axi_slave #(.FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rstn(rstn),
        .uart_axi_araddr(araddr), .uart_axi_arvalid(arvalid), .uart_axi_arready(arready),
        .uart_axi_rdata(rdata), .uart_axi_rresp(rresp), .uart_axi_rvalid(rvalid),
        .uart_axi_rready(rready),
        .uart_axi_awaddr(awaddr), .uart_axi_awvalid(awvalid), .uart_axi_awready(awready),
        .uart_axi_wdata(wdata), .uart_axi_wstrb(wstrb), .uart_axi_wvalid(wvalid),
        .uart_axi_wready(wready), .uart_axi_bresp(bresp), .uart_axi_bvalid(bvalid),
        .uart_axi_bready(bready),
        .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .interrupt(interrupt)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    logic [7:0] rxq[$];
    logic [7:0] txq[$];
    logic       m_ovr = 1'b0;
    logic       m_ie = 1'b0;
    logic       m_lat = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_stat();
        return {26'b0, m_ovr, m_ie, txq.size() == DEPTH, txq.size() == 0,
                rxq.size() == DEPTH, rxq.size() != 0};
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rx_send(input logic [7:0] b);
        rx_data = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1 rx_valid = 1'b0;
        if (rxq.size() < DEPTH) rxq.push_back(b);
        else m_ovr = 1'b1;
    endtask

    task automatic axi_read(input logic [3:0] addr, input int hold,
                            output logic [31:0] d, output logic [1:0] r);
        logic hs, ok;
        ok = 1'b0;
        araddr = addr;
        arvalid = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            hs = arready;
            @(posedge clk);
            #1;
            if (hs) begin
                ok = 1'b1;
                break;
            end
        end
        arvalid = 1'b0;
        check("ar_handshake", 32'(ok), 32'd1);
        rready = (hold == 0);
        @(negedge clk);
        check("rvalid_next", 32'(rvalid), 32'd1);
        d = rdata;
        r = rresp;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("rvalid_hold", 32'(rvalid), 32'd1);
            check("rdata_hold", rdata, d);
            check("arready_hold", 32'(arready), 32'd0);
        end
        rready = 1'b1;
        @(posedge clk);
        #1 rready = 1'b0;
        @(negedge clk);
        check("rvalid_drop", 32'(rvalid), 32'd0);
        check("arready_back", 32'(arready), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int aw_dly, input int w_dly, output logic [1:0] b);
        logic aw_done, w_done, ahs, whs, got;
        aw_done = 1'b0;
        w_done = 1'b0;
        got = 1'b0;
        b = 2'b11;
        awaddr = addr;
        wdata = data;
        wstrb = strb;
        for (int c = 0; c < 60; c++) begin
            awvalid = !aw_done && (c >= aw_dly);
            wvalid  = !w_done && (c >= w_dly);
            @(negedge clk);
            ahs = awvalid && awready;
            whs = wvalid && wready;
            @(posedge clk);
            #1;
            if (ahs) aw_done = 1'b1;
            if (whs) w_done = 1'b1;
            if (aw_done && w_done) break;
        end
        awvalid = 1'b0;
        wvalid = 1'b0;
        check("aw_w_handshake", 32'({aw_done, w_done}), 32'd3);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bvalid) begin
                got = 1'b1;
                b = bresp;
                break;
            end
            @(posedge clk);
            #1;
        end
        check("bvalid_seen", 32'(got), 32'd1);
        bready = 1'b1;
        @(posedge clk);
        #1 bready = 1'b0;
        @(negedge clk);
        check("bvalid_single", 32'(bvalid), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_read_rx(input int hold);
        logic [31:0] d, exp;
        logic [1:0] r;
        axi_read(4'h0 | 4'($urandom_range(0, 3)), hold, d, r);
        exp = (rxq.size() != 0) ? {24'b0, rxq.pop_front()} : 32'd0;
        check("rx_rdata", d, exp);
        check("rx_rresp", 32'(r), 32'd0);
    endtask

    task automatic do_read_stat(output logic [31:0] d);
        logic [31:0] exp;
        logic [1:0] r;
        exp = m_stat();
        axi_read(4'h8, $urandom_range(0, 2), d, r);
        check("stat_rdata", d, exp);
        check("stat_rresp", 32'(r), 32'd0);
        m_ovr = 1'b0;
        m_lat = 1'b0;
    endtask

    task automatic do_write_tx(input logic [7:0] v, input logic [3:0] strb, input int awd, input int wd);
        logic [1:0] b;
        axi_write(4'h4, {24'($urandom), v}, strb, awd, wd, b);
        check("tx_bresp", 32'(b), 32'd0);
        if (strb[0] && txq.size() < DEPTH) txq.push_back(v);
    endtask

    task automatic do_write_ctrl(input logic [7:0] v);
        logic [1:0] b;
        axi_write(4'hC, {24'b0, v}, 4'h1, $urandom_range(0, 2), $urandom_range(0, 2), b);
        check("ctrl_bresp", 32'(b), 32'd0);
        if (v[0]) begin
            if (txq.size() != 0) m_lat = 1'b1;
            txq.delete();
        end
        if (v[1]) rxq.delete();
        m_ie = v[4];
    endtask

    task automatic drain(input int k);
        for (int i = 0; i < k; i++) begin
            tx_ready = 1'b1;
            @(negedge clk);
            if (txq.size() != 0) begin
                check("tx_valid_drain", 32'(tx_valid), 32'd1);
                check("tx_data_drain", 32'(tx_data), 32'(txq.pop_front()));
                if (txq.size() == 0) m_lat = 1'b1;
            end else begin
                check("tx_valid_empty", 32'(tx_valid), 32'd0);
            end
            @(posedge clk);
            #1;
        end
        tx_ready = 1'b0;
    endtask

    task automatic check_state();
        idle(2);
        @(negedge clk);
        check("interrupt", 32'(interrupt), 32'(m_ie && (rxq.size() != 0 || m_lat)));
        check("tx_valid", 32'(tx_valid), 32'(txq.size() != 0));
        if (txq.size() != 0) check("tx_head", 32'(tx_data), 32'(txq[0]));
        @(posedge clk);
        #1;
    endtask

    task automatic do_bad();
        logic [31:0] d;
        logic [1:0] r, b;
        if ($urandom_range(0, 1) == 0) begin
            axi_read($urandom_range(0, 1) ? 4'h4 : 4'hC, $urandom_range(0, 2), d, r);
            check("bad_rd_rdata", d, 32'd0);
            check("bad_rd_rresp", 32'(r), 32'd2);
        end else begin
            axi_write($urandom_range(0, 1) ? 4'h0 : 4'h8, $urandom, 4'hF,
                      $urandom_range(0, 3), $urandom_range(0, 3), b);
            check("bad_wr_bresp", 32'(b), 32'd2);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic [1:0] r, b;

        // reset state and one-cycle delay before readies rise
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 32'({arready, awready, wready}), 32'd0);
        check("rst_valid", 32'({rvalid, bvalid, tx_valid, interrupt}), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_resp", 32'({rresp, bresp}), 32'd0);
        @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        check("post_rst_first", 32'({arready, awready, wready}), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("post_rst_ready", 32'({arready, awready, wready}), 32'd7);
        @(posedge clk);
        #1;

        // two RX bytes, three reads
        rx_send(8'h41);
        rx_send(8'h42);
        for (int i = 0; i < 3; i++) do_read_rx(0);
        check("rx_third_zero", 32'(rxq.size()), 32'd0);

        // W first, AW three cycles later
        do_write_tx(8'h55, 4'h1, 3, 0);
        check_state();
        check("tx_55", 32'(tx_data), 32'h55);
        drain(2);
        check_state();

        // RX overflow with one TX byte pending
        do_write_tx(8'h99, 4'h1, 0, 0);
        for (int i = 0; i < DEPTH + 1; i++) rx_send(8'($urandom));
        do_read_stat(d);
        check("stat_overrun", d, 32'h23);
        do_read_stat(d);
        check("stat_cleared", d, 32'h03);
        for (int i = 0; i < DEPTH; i++) do_read_rx(0);
        drain(1);
        check_state();

        // TX fill and overflow
        for (int i = 0; i < DEPTH; i++) do_write_tx(8'(i + 8'h10), 4'h1, $urandom_range(0, 2), $urandom_range(0, 2));
        do_write_tx(8'hAA, 4'h1, 0, 0);
        drain(DEPTH + 1);
        check_state();

        // illegal accesses with read backpressure
        do_read_stat(d);
        axi_read(4'h4, 5, d, r);
        check("slverr_rdata", d, 32'd0);
        check("slverr_rresp", 32'(r), 32'd2);
        axi_write(4'h8, 32'hFF, 4'hF, 0, 0, b);
        check("slverr_bresp", 32'(b), 32'd2);
        do_read_stat(d);

        // CTRL flush + interrupt enable
        rx_send(8'h01);
        do_write_tx(8'h02, 4'h1, 0, 1);
        do_write_ctrl(8'h13);
        check_state();
        do_read_stat(d);
        check("stat_ctrl", d, 32'h14);
        check_state();
        rx_send(8'h77);
        check_state();
        check("irq_rx", 32'(interrupt), 32'd1);

        // randomized operation mix
        for (int n = 0; n < 160; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: rx_send(8'($urandom));
                3:       do_read_rx($urandom_range(0, 2));
                4:       do_read_stat(d);
                5, 6:    do_write_tx(8'($urandom), 4'($urandom_range(0, 15) | ($urandom_range(0, 3) != 0 ? 1 : 0)),
                                     $urandom_range(0, 3), $urandom_range(0, 3));
                7:       drain($urandom_range(1, 4));
                8:       do_write_ctrl({3'b0, 1'($urandom), 2'b0,
                                        1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0)});
                default: do_bad();
            endcase
            check_state();
        end

        // asynchronous reset during an outstanding read
        rx_send(8'h5A);
        do_write_tx(8'hA5, 4'h1, 0, 0);
        araddr = 4'h0;
        arvalid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (arready) break;
        end
        @(posedge clk);
        #1 arvalid = 1'b0;
        @(negedge clk);
        check("pre_rst_rvalid", 32'(rvalid), 32'd1);
        rstn = 1'b0;
        #1;
        check("mid_rst_rvalid", 32'(rvalid), 32'd0);
        check("mid_rst_txvalid", 32'(tx_valid), 32'd0);
        check("mid_rst_arready", 32'(arready), 32'd0);
        @(posedge clk);
        #1 rstn = 1'b1;
        rxq.delete();
        txq.delete();
        m_ovr = 1'b0;
        m_ie = 1'b0;
        m_lat = 1'b0;
        idle(2);
        do_read_stat(d);
        check("stat_after_rst", d, 32'h04);
        do_read_rx(0);
        check_state();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
